rosc_meas_sequencer: RTL and testbench

- Measurement sequencer and edge counter directly downstream of the stacked RVT stress ring-oscillator block.
- Drives that block's control pins: SEL_INV97/99/101, START, EN_ROSC, EN_POWER_ROSC, MEAS_STRESS.
- Consumes its OUT pin and counts synchronized rising edges over a programmable window of CLK cycles.
- Reports a frequency code to the odometer readout logic. Outside a measurement, the ring oscillators are held in stress mode.

---
 rtl/rosc_meas_sequencer_if.sv | 25 ++
 rtl/rosc_meas_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_rosc_meas_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rosc_meas_sequencer_if.sv
// Request/result bus between the odometer readout logic and rosc_meas_sequencer.
// The readout side is the master; the sequencer is the slave.
interface rosc_meas_sequencer_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) ();
    logic             MEAS_REQ;
    logic [1:0]       ROSC_SEL;
    logic [WIN_W-1:0] WIN_CYCLES;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] COUNT;
    logic             OVF;
    logic             ERR;

    modport master (
        output MEAS_REQ, ROSC_SEL, WIN_CYCLES,
        input  BUSY, DONE, COUNT, OVF, ERR
    );

    modport slave (
        input  MEAS_REQ, ROSC_SEL, WIN_CYCLES,
        output BUSY, DONE, COUNT, OVF, ERR
    );
endinterface

// File: rtl/rosc_meas_sequencer.sv
// Measurement sequencer and edge counter for the stacked RVT stress ring-oscillator block.
// Define ROSC_MEAS_AVG4_EN to average four RUN+DRAIN passes per request.
module rosc_meas_sequencer #(
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic ROSC_OUT,
    output logic SEL_INV97,
    output logic SEL_INV99,
    output logic SEL_INV101,
    output logic START,
    output logic EN_ROSC,
    output logic EN_POWER_ROSC,
    output logic MEAS_STRESS,
    rosc_meas_sequencer_if.slave bus
);

    localparam int TMR_W = (WIN_W > 8) ? WIN_W : 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        DRAIN,
        REPORT,
        REJECT
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [WIN_W-1:0] win_q;
    logic [2:0]       sel_oh, sel_dec;
    logic             accept, reject, win_zero;
    logic             busy_nxt, stress_nxt, en_rosc_nxt, start_nxt;

    logic             sync1, sync2, sync3, rise;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sat, ovf_run;

`ifdef ROSC_MEAS_AVG4_EN
    localparam int ACC_W = CNT_W + 2;
    logic [1:0]       pass_q, pass_nxt;
    logic [ACC_W-1:0] acc;
`endif

    assign accept   = (state == IDLE) && bus.MEAS_REQ && (bus.ROSC_SEL != 2'd3);
    assign reject   = (state == IDLE) && bus.MEAS_REQ && (bus.ROSC_SEL == 2'd3);
    assign win_zero = (win_q == '0);

    assign {SEL_INV101, SEL_INV99, SEL_INV97} = sel_oh;

    always_comb begin
        sel_dec = 3'b000;
        case (bus.ROSC_SEL)
            2'd0:    sel_dec = 3'b001;
            2'd1:    sel_dec = 3'b010;
            2'd2:    sel_dec = 3'b100;
            default: sel_dec = 3'b000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            tmr    <= '0;
`ifdef ROSC_MEAS_AVG4_EN
            pass_q <= '0;
`endif
        end else begin
            state  <= state_nxt;
            tmr    <= tmr_nxt;
`ifdef ROSC_MEAS_AVG4_EN
            pass_q <= pass_nxt;
`endif
        end
    end

    // tmr holds the remaining cycles of the current state minus one
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
`ifdef ROSC_MEAS_AVG4_EN
        pass_nxt  = pass_q;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SETUP;
                    tmr_nxt   = TMR_W'(SETTLE_CYC - 1);
                end else if (reject) begin
                    state_nxt = REJECT;
                end
            end
            SETUP: begin
                if (tmr == '0) begin
`ifdef ROSC_MEAS_AVG4_EN
                    pass_nxt = '0;
`endif
                    if (win_zero) begin
                        state_nxt = DRAIN;
                        tmr_nxt   = TMR_W'(2);
                    end else begin
                        state_nxt = RUN;
                        tmr_nxt   = TMR_W'(win_q) - TMR_W'(1);
                    end
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            RUN: begin
                if (tmr == '0) begin
                    state_nxt = DRAIN;
                    tmr_nxt   = TMR_W'(2);
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            DRAIN: begin
                if (tmr == '0) begin
`ifdef ROSC_MEAS_AVG4_EN
                    if (pass_q != 2'd3) begin
                        pass_nxt = pass_q + 2'd1;
                        if (win_zero) begin
                            state_nxt = DRAIN;
                            tmr_nxt   = TMR_W'(2);
                        end else begin
                            state_nxt = RUN;
                            tmr_nxt   = TMR_W'(win_q) - TMR_W'(1);
                        end
                    end else begin
                        state_nxt = REPORT;
                    end
`else
                    state_nxt = REPORT;
`endif
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            REPORT:  state_nxt = IDLE;
            REJECT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        busy_nxt    = 1'b0;
        stress_nxt  = 1'b0;
        en_rosc_nxt = 1'b0;
        start_nxt   = 1'b0;
        case (state_nxt)
            SETUP, DRAIN, REPORT: begin
                busy_nxt    = 1'b1;
                stress_nxt  = 1'b1;
                en_rosc_nxt = 1'b1;
            end
            RUN: begin
                busy_nxt    = 1'b1;
                stress_nxt  = 1'b1;
                en_rosc_nxt = 1'b1;
                start_nxt   = 1'b1;
            end
            default: ;
        endcase
    end

    assign rise = sync2 & ~sync3;

    always_comb begin
        cnt_nxt = cnt;
        sat     = 1'b0;
        if ((state == RUN || state == DRAIN) && rise) begin
            if (cnt == '1) begin
                sat = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // Control pins are registered from the next state so they never glitch toward the oscillator block
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            sync3         <= 1'b0;
            cnt           <= '0;
            ovf_run       <= 1'b0;
            win_q         <= '0;
            sel_oh        <= '0;
            START         <= 1'b0;
            EN_ROSC       <= 1'b0;
            EN_POWER_ROSC <= 1'b0;
            MEAS_STRESS   <= 1'b0;
            bus.BUSY      <= 1'b0;
            bus.DONE      <= 1'b0;
            bus.COUNT     <= '0;
            bus.OVF       <= 1'b0;
            bus.ERR       <= 1'b0;
`ifdef ROSC_MEAS_AVG4_EN
            acc           <= '0;
`endif
        end else begin
            sync1         <= ROSC_OUT;
            sync2         <= sync1;
            sync3         <= sync2;
            START         <= start_nxt;
            EN_ROSC       <= en_rosc_nxt;
            EN_POWER_ROSC <= 1'b1;
            MEAS_STRESS   <= stress_nxt;
            bus.BUSY      <= busy_nxt;
            bus.DONE      <= (state == REPORT) || (state == REJECT);

            if (state == IDLE && bus.MEAS_REQ) begin
                sel_oh <= sel_dec;
            end
            if (accept) begin
                win_q <= bus.WIN_CYCLES;
            end

            if (state == SETUP) begin
                cnt     <= '0;
                ovf_run <= 1'b0;
`ifdef ROSC_MEAS_AVG4_EN
                acc     <= '0;
`endif
            end else begin
                cnt     <= cnt_nxt;
                ovf_run <= ovf_run | sat;
`ifdef ROSC_MEAS_AVG4_EN
                if (state == DRAIN && tmr == '0) begin
                    acc <= acc + ACC_W'(cnt_nxt);
                    cnt <= '0;
                end
`endif
            end

            if (state == REPORT) begin
`ifdef ROSC_MEAS_AVG4_EN
                bus.COUNT <= CNT_W'(acc >> 2);
`else
                bus.COUNT <= cnt;
`endif
                bus.OVF   <= ovf_run;
                bus.ERR   <= 1'b0;
            end else if (state == REJECT) begin
                bus.ERR   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rosc_meas_sequencer.sv
// Self-checking bench for rosc_meas_sequencer: a 16-bit and an 8-bit counter instance share
// clock, reset and oscillator; vectors go through a scoreboard queue checked at each DONE.
module tb_rosc_meas_sequencer;

    localparam int SETTLE = 8;

    typedef struct {
        bit          dut8;
        logic [1:0]  sel;
        logic [15:0] win;
        int          period;
        int          exp_count;
        int          tol;
        bit          exp_ovf;
        bit          exp_err;
        logic [2:0]  exp_sel;
        bit          exp_start;
        int          t0;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        rosc_out;
    int          osc_period;
    logic        dsel;
    logic        meas_req;
    logic [1:0]  rosc_sel;
    logic [15:0] win_cycles;
    int          cyc;
    int          n_checks;
    int          n_errors;
    vec_t        exp_q[$];
    vec_t        vecs[6];

    logic s97_16, s99_16, s101_16, start_16, en_rosc_16, en_pwr_16, stress_16;
    logic s97_8,  s99_8,  s101_8,  start_8,  en_rosc_8,  en_pwr_8,  stress_8;

    rosc_meas_sequencer_if #(.CNT_W(16), .WIN_W(16)) bus16 ();
    rosc_meas_sequencer_if #(.CNT_W(8),  .WIN_W(16)) bus8 ();

    assign bus16.MEAS_REQ   = meas_req & ~dsel;
    assign bus16.ROSC_SEL   = rosc_sel;
    assign bus16.WIN_CYCLES = win_cycles;
    assign bus8.MEAS_REQ    = meas_req & dsel;
    assign bus8.ROSC_SEL    = rosc_sel;
    assign bus8.WIN_CYCLES  = win_cycles;

    rosc_meas_sequencer #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(SETTLE)) dut16 (
        .CLK(clk), .RST(rst), .ROSC_OUT(rosc_out),
        .SEL_INV97(s97_16), .SEL_INV99(s99_16), .SEL_INV101(s101_16),
        .START(start_16), .EN_ROSC(en_rosc_16), .EN_POWER_ROSC(en_pwr_16),
        .MEAS_STRESS(stress_16), .bus(bus16)
    );

    rosc_meas_sequencer #(.CNT_W(8), .WIN_W(16), .SETTLE_CYC(SETTLE)) dut8 (
        .CLK(clk), .RST(rst), .ROSC_OUT(rosc_out),
        .SEL_INV97(s97_8), .SEL_INV99(s99_8), .SEL_INV101(s101_8),
        .START(start_8), .EN_ROSC(en_rosc_8), .EN_POWER_ROSC(en_pwr_8),
        .MEAS_STRESS(stress_8), .bus(bus8)
    );

    wire [2:0]  sel_m    = dsel ? {s101_8, s99_8, s97_8} : {s101_16, s99_16, s97_16};
    wire        start_m  = dsel ? start_8    : start_16;
    wire        en_ros_m = dsel ? en_rosc_8  : en_rosc_16;
    wire        en_pwr_m = dsel ? en_pwr_8   : en_pwr_16;
    wire        stress_m = dsel ? stress_8   : stress_16;
    wire        busy_m   = dsel ? bus8.BUSY  : bus16.BUSY;
    wire        done_m   = dsel ? bus8.DONE  : bus16.DONE;
    wire        ovf_m    = dsel ? bus8.OVF   : bus16.OVF;
    wire        err_m    = dsel ? bus8.ERR   : bus16.ERR;
    wire [15:0] count_m  = dsel ? {8'd0, bus8.COUNT} : bus16.COUNT;
    wire [26:0] all_out  = {sel_m, start_m, en_ros_m, en_pwr_m, stress_m,
                            busy_m, done_m, ovf_m, err_m, count_m};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transitions sit at 2 ns past a multiple of 5 ns, never on a clock edge
    initial begin
        rosc_out = 1'b0;
        #2;
        forever begin
            if (osc_period == 0) begin
                rosc_out = 1'b0;
                #10;
            end else begin
                rosc_out = 1'b1;
                #(osc_period * 5);
                rosc_out = 1'b0;
                #(osc_period * 5);
            end
        end
    end

    function automatic int exp_lat(int win, bit err);
        if (err) return 1;
`ifdef ROSC_MEAS_AVG4_EN
        return SETTLE + 4 * (win + 3) + 1;
`else
        return SETTLE + win + 4;
`endif
    endfunction

    task automatic check_range(string name, longint act, longint lo, longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        dsel       = v.dut8;
        osc_period = v.period;
        rosc_sel   = v.sel;
        win_cycles = v.win;
        meas_req   = 1'b1;
        @(posedge clk);
        #1;
        meas_req   = 1'b0;
        rosc_sel   = 2'd0;
        win_cycles = 16'd7;
        e          = v;
        e.t0       = cyc;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(string tag);
        vec_t     e;
        bit       found;
        logic [2:0] sel_seen;
        bit       start_seen;
        found      = 1'b0;
        sel_seen   = 3'b000;
        start_seen = 1'b0;
        for (int k = 0; k < 6000 && !found; k++) begin
            @(posedge clk);
            #1;
            sel_seen   = sel_seen | sel_m;
            start_seen = start_seen | start_m;
            if (done_m) found = 1'b1;
        end
        e = exp_q.pop_front();
        if (!found) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL %s done: no DONE within 6000 cycles", tag);
            return;
        end
        check_range({tag, " latency"}, cyc - e.t0, exp_lat(e.win, e.exp_err), exp_lat(e.win, e.exp_err));
        check_range({tag, " count"}, count_m, e.exp_count - e.tol, e.exp_count + e.tol);
        if (!e.exp_err) check_range({tag, " ovf"}, ovf_m, e.exp_ovf, e.exp_ovf);
        check_range({tag, " err"}, err_m, e.exp_err, e.exp_err);
        check_range({tag, " sel"}, sel_seen, e.exp_sel, e.exp_sel);
        check_range({tag, " start"}, start_seen, e.exp_start, e.exp_start);
        check_range({tag, " busy at done"}, busy_m, 0, 0);
        @(posedge clk);
        #1;
        check_range({tag, " done pulse"}, done_m, 0, 0);
    endtask

    initial begin
        vec_t v;
        int   extra;

        //           dut8 sel  win    per cnt  tol ovf err sel     start t0
        vecs[0] = '{1'b0, 2'd1, 16'd800,  8, 100, 1, 1'b0, 1'b0, 3'b010, 1'b1, 0};
        vecs[1] = '{1'b1, 2'd0, 16'd1000, 3, 255, 0, 1'b1, 1'b0, 3'b001, 1'b1, 0};
        vecs[2] = '{1'b1, 2'd2, 16'd80,   8, 10,  1, 1'b0, 1'b0, 3'b100, 1'b1, 0};
        vecs[3] = '{1'b0, 2'd3, 16'd50,   8, 100, 1, 1'b0, 1'b1, 3'b000, 1'b0, 0};
        vecs[4] = '{1'b0, 2'd2, 16'd0,    8, 0,   0, 1'b0, 1'b0, 3'b100, 1'b0, 0};
        vecs[5] = '{1'b0, 2'd0, 16'd40,   5, 8,   1, 1'b0, 1'b0, 3'b001, 1'b1, 0};

        cyc        = 0;
        n_checks   = 0;
        n_errors   = 0;
        osc_period = 0;
        dsel       = 1'b0;
        meas_req   = 1'b0;
        rosc_sel   = 2'd1;
        win_cycles = 16'd10;
        rst        = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_range($sformatf("reset outputs %0d", i), all_out, 0, 0);
            meas_req = ~meas_req;
        end
        meas_req = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        check_range("idle en_power", en_pwr_m, 1, 1);
        check_range("idle stress", stress_m, 0, 0);
        check_range("idle busy", busy_m, 0, 0);
        $display("[TB] reset and idle checked");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        v = '{1'b0, 2'd1, 16'd100, 8, 12, 1, 1'b0, 1'b0, 3'b010, 1'b1, 0};
        applyStimulus(v);
        repeat (40) @(posedge clk);
        #1;
        rosc_sel   = 2'd2;
        win_cycles = 16'd5;
        meas_req   = 1'b1;
        @(posedge clk);
        #1;
        meas_req   = 1'b0;
        checkOutput("busy reject");
        extra = 0;
        for (int k = 0; k < 150; k++) begin
            @(posedge clk);
            #1;
            if (done_m) extra++;
        end
        check_range("busy reject extra done", extra, 0, 0);

        v = '{1'b0, 2'd0, 16'd100, 8, 12, 1, 1'b0, 1'b0, 3'b001, 1'b1, 0};
        applyStimulus(v);
        repeat (40) @(posedge clk);
        #1;
        void'(exp_q.pop_back());
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_range("midrun reset outputs", all_out, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_range("post reset en_power", en_pwr_m, 1, 1);
        check_range("post reset busy", busy_m, 0, 0);
        applyStimulus(vecs[5]);
        checkOutput("after reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
